// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave is the cache; master is the IF stage plus mem_ctrl.
interface icache_if;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        abort;
   logic        flush;
   logic        fetch_done;
   logic [31:0] fetch_inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_inst;

   modport master (
      output fetch_req, fetch_addr, abort, flush, mem_done, mem_inst,
      input  fetch_done, fetch_inst, mem_req, mem_addr
   );

   modport slave (
      input  fetch_req, fetch_addr, abort, flush, mem_done, mem_inst,
      output fetch_done, fetch_inst, mem_req, mem_addr
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// A miss issues a single-word refill to mem_ctrl; abort and flush never drop an in-flight refill.
module icache #(
   parameter int unsigned INDEX_BITS = 7
) (
   input logic     clk,
   input logic     rst,
   input logic     rdy,
   icache_if.slave bus
);

   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 16 - INDEX_BITS;

   typedef enum logic {StIdle, StMiss} state_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic                cancel_q, cancel_d;
   logic                flushed_q, flushed_d;
   logic                done_q, done_d;
   logic [31:0]         inst_q, inst_d;
   logic                mem_req_q, mem_req_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic                wr_en;

   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [INDEX_BITS-1:0] idx, ridx;
   logic [TAG_BITS-1:0]   tag, rtag;
   logic                  hit;

   assign idx  = bus.fetch_addr[INDEX_BITS+1:2];
   assign tag  = bus.fetch_addr[17:INDEX_BITS+2];
   // Refill location comes from the latched miss address, not the live fetch_addr.
   assign ridx = mem_addr_q[INDEX_BITS+1:2];
   assign rtag = mem_addr_q[17:INDEX_BITS+2];
   assign hit  = valid_q[idx] && (tag_mem[idx] == tag);

   logic unused_bits;
   assign unused_bits = ^{bus.fetch_addr[31:18], bus.fetch_addr[1:0]};

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      cancel_d   = cancel_q;
      flushed_d  = flushed_q;
      done_d     = 1'b0;
      inst_d     = inst_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      wr_en      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.fetch_req && !bus.abort) begin
               // A flush in the same cycle turns a would-be hit into a miss.
               if (hit && !bus.flush) begin
                  done_d = 1'b1;
                  inst_d = data_mem[idx];
               end else begin
                  state_d    = StMiss;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {14'b0, bus.fetch_addr[17:2], 2'b00};
                  cancel_d   = 1'b0;
                  flushed_d  = 1'b0;
               end
            end
         end
         StMiss: begin
            if (bus.abort) cancel_d = 1'b1;
            if (bus.flush) flushed_d = 1'b1;
            if (bus.mem_done) begin
               wr_en     = 1'b1;
               state_d   = StIdle;
               mem_req_d = 1'b0;
               cancel_d  = 1'b0;
               flushed_d = 1'b0;
               if (!(cancel_q || bus.abort)) begin
                  done_d = 1'b1;
                  inst_d = bus.mem_inst;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (bus.flush) valid_d = '0;
      // Data fetched across a flush is delivered but must not be trusted later.
      if (wr_en) valid_d[ridx] = !(flushed_q || bus.flush);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         valid_q    <= '0;
         cancel_q   <= 1'b0;
         flushed_q  <= 1'b0;
         done_q     <= 1'b0;
         inst_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         cancel_q   <= cancel_d;
         flushed_q  <= flushed_d;
         done_q     <= done_d;
         inst_q     <= inst_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && wr_en) begin
         tag_mem[ridx]  <= rtag;
         data_mem[ridx] <= bus.mem_inst;
      end
   end

   assign bus.fetch_done = done_q;
   assign bus.fetch_inst = inst_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 7, line-index width; 2^INDEX_BITS direct-mapped lines of one 32-bit word each.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rdy  input  1  pause when low: no register or array updates, all outputs hold.
REQ-005 fetch_req  input  1  IF stage requests instruction at fetch_addr; held until fetch_done.
REQ-006 fetch_addr  input  32  byte address; bits [1:0] ignored, bits [31:18] ignored.
REQ-007 abort  input  1  jump taken; cancel delivery of the outstanding fetch.
REQ-008 flush  input  1  invalidate every line.
REQ-009 fetch_done  output  1  one-cycle pulse, fetch_inst valid.
REQ-010 fetch_inst  output  32  instruction word.
REQ-011 mem_req  output  1  word-fetch request to mem_ctrl, held until mem_done.
REQ-012 mem_addr  output  32  word-aligned refill address {14'b0, fetch_addr[17:2], 2'b00}.
REQ-013 mem_done  input  1  one-cycle pulse, mem_inst valid.
REQ-014 mem_inst  input  32  refill word.

Function
REQ-015 Index = fetch_addr[INDEX_BITS+1:2]; tag = fetch_addr[17:INDEX_BITS+2]; per line: valid bit, tag, data.
REQ-016 States IDLE and MISS only.
REQ-017 IDLE, fetch_req=1, hit (valid and tag equal), abort=0: fetch_done=1 and fetch_inst=line data in the next cycle; state stays IDLE.
REQ-018 Back-to-back hits SHALL sustain one fetch_done per cycle.
REQ-019 IDLE, fetch_req=1, miss, abort=0: next cycle state MISS, mem_req=1, mem_addr per REQ-012; fetch_done=0.
REQ-020 MISS: mem_req and mem_addr held constant; fetch_req and fetch_addr ignored.
REQ-021 MISS, mem_done=1: line written (valid=1, tag, data=mem_inst); next cycle mem_req=0, state IDLE, fetch_done=1, fetch_inst=mem_inst, unless cancelled.
REQ-022 Refill-to-fetch_done latency exactly 1 cycle; a new request SHALL be accepted in that same cycle.
REQ-023 abort in IDLE: request in that cycle not accepted, no fetch_done next cycle.
REQ-024 abort in MISS, or on the mem_done cycle: cancel flag set; refill still completes and writes the line; fetch_done not pulsed; state returns IDLE.
REQ-025 The in-flight mem_req SHALL never be dropped before mem_done, whatever abort or flush does.
REQ-026 flush: all valid bits clear at the next edge.
REQ-027 Flush in IDLE with fetch_req: request treated as a miss.
REQ-028 Flush during MISS, or on the mem_done cycle: refill data still delivered via fetch_done (if not aborted); line NOT marked valid.
REQ-029 fetch_done=0 in every cycle not covered by REQ-017/REQ-021.
REQ-030 fetch_inst holds its last value when fetch_done=0.

Reset
REQ-031 rst=1 at an edge: state IDLE, all valid bits 0, cancel flag 0, fetch_done 0, fetch_inst 0, mem_req 0, mem_addr 0.
REQ-032 rst overrides rdy=0.
REQ-033 rst mid-MISS abandons the refill; a later mem_done is ignored in IDLE.
REQ-034 Tag and data arrays need no reset.

Verification
REQ-035 Cold miss: reset, fetch 0x00000004, mem_done with 0x00A00093 after 4 cycles -> mem_addr=0x00000004 during MISS; fetch_done one cycle after mem_done with 0x00A00093; refetch 0x4 hits with 1-cycle latency, mem_req stays 0.
REQ-036 Conflict: INDEX_BITS=7, fill 0x00000010, then fetch 0x00000210 -> miss, mem_addr=0x00000210; then 0x00000010 misses again.
REQ-037 Abort: miss on 0x100, abort mid-MISS, mem_done=0x12345678 -> no fetch_done; later fetch 0x100 hits returning 0x12345678.
REQ-038 Flush: fill 0x20 and 0x24, pulse flush, fetch 0x20 -> miss with mem_req; flush during that MISS -> fetch_done delivered, next fetch 0x20 misses again.
REQ-039 Pause: rdy=0 for 3 cycles during MISS with mem_done held 0 -> mem_req, mem_addr, state unchanged; on resume refill completes normally.
REQ-040 Streaming: 8 sequential prefilled addresses 0x0..0x1C with fetch_req held -> 8 consecutive fetch_done pulses, correct words in order.
